// File: rtl/lf_field_sched.sv
// LF read sequencer: free-running carrier timebase, ON/OFF burst scheduler and decimated sample gate.
// Optional LF_SCHED_STATS_EN adds a saturating burst counter output (burst_cnt).
module lf_field_sched #(
    parameter int DEF_DIV = 95,
    parameter int PH_W    = 16,
    parameter int DEC_W   = 4
) (
    input  logic             pck0,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [7:0]       cfg_div,
    input  logic [PH_W-1:0]  cfg_on,
    input  logic [PH_W-1:0]  cfg_off,
    input  logic [DEC_W-1:0] cfg_decim,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       pck_cnt,
    output logic             pck_divclk,
    output logic             lf_field,
    output logic             sample_gate,
    output logic             period_end,
    output logic             busy
`ifdef LF_SCHED_STATS_EN
    ,
    output logic [15:0]      burst_cnt
`endif
);

    // state      | meaning
    // S_IDLE     | no schedule, field off; waits for start then first period boundary
    // S_ON       | carrier enabled, counting ON periods
    // S_OFF      | carrier gap, counting OFF periods
    // S_STOPPING | one settling period with field and gate off before IDLE
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_STOPPING} state_t;

    localparam logic [7:0] MIN_DIV   = 8'd15;
    localparam logic [7:0] RST_DIV   = (DEF_DIV < 15) ? MIN_DIV : 8'(DEF_DIV);
    localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

    state_t            state, state_nx;
    logic [PH_W-1:0]   phase_cnt, phase_nx;
    logic [DEC_W-1:0]  decim_cnt, decim_nx, decim_inc;
    logic              field_nx, gate_nx;
    logic              start_req, stop_req, start_ok, run_state;
    logic [7:0]        div_act, div_sh;
    logic [PH_W-1:0]   on_act, on_sh, off_act, off_sh;
    logic [DEC_W-1:0]  decim_act, decim_sh;
    logic              pend;

    assign period_end = (pck_cnt == div_act) && pck_divclk;
    assign busy       = (state != S_IDLE) || start_req;
    assign run_state  = (state == S_ON) || (state == S_OFF);
    assign start_ok   = start && !stop && !busy;

    always_comb begin
        state_nx  = state;
        phase_nx  = phase_cnt;
        decim_nx  = decim_cnt;
        field_nx  = lf_field;
        gate_nx   = sample_gate;
        decim_inc = (decim_cnt >= decim_act) ? '0 : decim_cnt + DEC_W'(1);
        if (period_end) begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state_nx = S_ON;
                        phase_nx = '0;
                        decim_nx = '0;
                    end
                end
                S_ON: begin
                    if (stop_req) begin
                        state_nx = S_STOPPING;
                    end else begin
                        decim_nx = decim_inc;
                        if (phase_cnt >= on_act - PH_ONE) begin
                            phase_nx = '0;
                            if (off_act != '0) state_nx = S_OFF;
                        end else begin
                            phase_nx = phase_cnt + PH_ONE;
                        end
                    end
                end
                S_OFF: begin
                    if (stop_req) begin
                        state_nx = S_STOPPING;
                    end else begin
                        decim_nx = decim_inc;
                        if (phase_cnt >= off_act - PH_ONE) begin
                            phase_nx = '0;
                            state_nx = S_ON;
                        end else begin
                            phase_nx = phase_cnt + PH_ONE;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
            // Outputs only move on a period boundary so bursts hold whole periods.
            field_nx = (state_nx == S_ON);
            gate_nx  = ((state_nx == S_ON) || (state_nx == S_OFF)) && (decim_nx == '0);
        end
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            pck_cnt     <= '0;
            pck_divclk  <= 1'b0;
            state       <= S_IDLE;
            phase_cnt   <= '0;
            decim_cnt   <= '0;
            lf_field    <= 1'b0;
            sample_gate <= 1'b0;
            start_req   <= 1'b0;
            stop_req    <= 1'b0;
            div_act     <= RST_DIV;
            div_sh      <= RST_DIV;
            on_act      <= PH_ONE;
            on_sh       <= PH_ONE;
            off_act     <= '0;
            off_sh      <= '0;
            decim_act   <= '0;
            decim_sh    <= '0;
            pend        <= 1'b0;
        end else begin
            if (pck_cnt == div_act) begin
                pck_cnt    <= '0;
                pck_divclk <= ~pck_divclk;
            end else begin
                pck_cnt <= pck_cnt + 8'd1;
            end

            state       <= state_nx;
            phase_cnt   <= phase_nx;
            decim_cnt   <= decim_nx;
            lf_field    <= field_nx;
            sample_gate <= gate_nx;

            if (start_ok)
                start_req <= 1'b1;
            else if (period_end && state == S_IDLE)
                start_req <= 1'b0;

            if (run_state) begin
                if (period_end && stop_req) stop_req <= 1'b0;
                else if (stop)              stop_req <= 1'b1;
            end else begin
                stop_req <= 1'b0;
            end

            // A load coinciding with a boundary lands in shadow and waits one more period.
            if (period_end && pend) begin
                div_act   <= div_sh;
                on_act    <= on_sh;
                off_act   <= off_sh;
                decim_act <= decim_sh;
            end
            if (cfg_load) begin
                div_sh   <= (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
                on_sh    <= (cfg_on == '0) ? PH_ONE : cfg_on;
                off_sh   <= cfg_off;
                decim_sh <= cfg_decim;
                pend     <= 1'b1;
            end else if (period_end) begin
                pend <= 1'b0;
            end
        end
    end

`ifdef LF_SCHED_STATS_EN
    always_ff @(posedge pck0) begin
        if (rst)
            burst_cnt <= '0;
        else if (start_ok)
            burst_cnt <= '0;
        else if (state == S_ON && state_nx == S_OFF && burst_cnt != 16'hFFFF)
            burst_cnt <= burst_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lf_field_sched.sv
// Bench for lf_field_sched: timebase, clamp, burst/decimation scoreboard, stop, reset and stats.
module tb_lf_field_sched;

    logic        pck0 = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [7:0]  cfg_div = 8'd95;
    logic [15:0] cfg_on = 16'd1;
    logic [15:0] cfg_off = 16'd0;
    logic [3:0]  cfg_decim = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  pck_cnt;
    logic        pck_divclk, lf_field, sample_gate, period_end, busy;
`ifdef LF_SCHED_STATS_EN
    logic [15:0] burst_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [1:0] exp_q[$];

    lf_field_sched dut (
        .pck0(pck0), .rst(rst), .cfg_load(cfg_load), .cfg_div(cfg_div),
        .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_decim(cfg_decim),
        .start(start), .stop(stop), .pck_cnt(pck_cnt), .pck_divclk(pck_divclk),
        .lf_field(lf_field), .sample_gate(sample_gate), .period_end(period_end),
        .busy(busy)
`ifdef LF_SCHED_STATS_EN
        , .burst_cnt(burst_cnt)
`endif
    );

    always #5 pck0 = ~pck0;

    // Advance to the next negedge on which period_end is high.
    task automatic wait_pe(input string tag);
        int k = 0;
        @(negedge pck0);
        while (period_end !== 1'b1 && k < 1000) begin
            @(negedge pck0);
            k++;
        end
        if (period_end !== 1'b1) begin
            n_chk++;
            $display("FAIL %s: period_end timeout", tag);
        end
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            @(negedge pck0);
            n++;
        end while (period_end !== 1'b1 && n < 1000);
    endtask

    task automatic load_cfg(input logic [7:0] d, input logic [15:0] on, input logic [15:0] off,
                            input logic [3:0] dec);
        @(negedge pck0);
        cfg_div = d; cfg_on = on; cfg_off = off; cfg_decim = dec; cfg_load = 1'b1;
        @(negedge pck0);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge pck0);
        start = 1'b1;
        @(negedge pck0);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge pck0);
        stop = 1'b1;
        @(negedge pck0);
        stop = 1'b0;
    endtask

    // Pop one expected {lf_field, sample_gate} per period on its first cycle.
    task automatic run_sched(input int n, input string tag);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            wait_pe(tag);
            @(negedge pck0);
            e = exp_q.pop_front();
            n_chk++;
            if ({lf_field, sample_gate} !== e || busy !== 1'b1 || pck_cnt !== 8'd0)
                $display("FAIL %s[%0d]: field/gate/busy/cnt=%b%b%b/%0d want %b1/0",
                         tag, i, lf_field, sample_gate, busy, pck_cnt, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pck0);
        n_chk++;
        if ({pck_cnt, pck_divclk, lf_field, sample_gate, period_end, busy} !== 13'd0)
            $display("FAIL reset: outs=%h want 0",
                     {pck_cnt, pck_divclk, lf_field, sample_gate, period_end, busy});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_timebase();
        int n, k;
        logic prev;
        wait_pe("tb_pe");
        for (int i = 0; i < 2; i++) begin
            measure(n);
            n_chk++;
            if (n !== 192) $display("FAIL pe_interval: got %0d want 192", n);
            else n_pass++;
        end
        k = 0; prev = pck_divclk;
        @(negedge pck0);
        while (!(prev == 1'b0 && pck_divclk == 1'b1) && k < 500) begin
            prev = pck_divclk; @(negedge pck0); k++;
        end
        n = 0; prev = pck_divclk;
        do begin
            prev = pck_divclk; @(negedge pck0); n++;
        end while (!(prev == 1'b0 && pck_divclk == 1'b1) && n < 500);
        n_chk++;
        if (n !== 192 || lf_field !== 1'b0 || busy !== 1'b0)
            $display("FAIL divclk_period: got %0d field=%b busy=%b want 192/0/0", n, lf_field, busy);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int n;
        load_cfg(8'd10, 16'd1, 16'd0, 4'd0);
        wait_pe("clamp_apply");
        for (int i = 0; i < 2; i++) begin
            measure(n);
            n_chk++;
            if (n !== 32) $display("FAIL clamp_period: got %0d want 32", n);
            else n_pass++;
        end
        load_cfg(8'd95, 16'd1, 16'd0, 4'd0);
        wait_pe("clamp_restore");
        measure(n);
        n_chk++;
        if (n !== 192) $display("FAIL restore_period: got %0d want 192", n);
        else n_pass++;
    endtask

    task automatic test_burst();
        load_cfg(8'd95, 16'd3, 16'd2, 4'd0);
        wait_pe("burst_apply");
        pulse_start();
        n_chk++;
        if (busy !== 1'b1 || lf_field !== 1'b0)
            $display("FAIL start_busy: busy=%b field=%b want 1/0", busy, lf_field);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back(2'b11);
            for (int i = 0; i < 2; i++) exp_q.push_back(2'b01);
        end
        run_sched(10, "burst");
    endtask

    task automatic test_stop();
        int n;
        pulse_stop();
        exp_q.push_back(2'b00);
        run_sched(1, "stopping");
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge pck0); n++;
        end
        n_chk++;
        if (n !== 192 || lf_field !== 1'b0)
            $display("FAIL stop_busy_drop: got %0d field=%b want 192/0", n, lf_field);
        else n_pass++;
    endtask

    task automatic test_decim();
        int n;
        load_cfg(8'd95, 16'd3, 16'd0, 4'd3);
        wait_pe("decim_apply");
        pulse_start();
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, (i % 4) == 0});
        run_sched(8, "decim");
        pulse_stop();
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge pck0); n++;
        end
        n_chk++;
        if (busy !== 1'b0 || lf_field !== 1'b0)
            $display("FAIL decim_stop: busy=%b field=%b want 0/0", busy, lf_field);
        else n_pass++;
    endtask

    task automatic test_start_stop_same();
        @(negedge pck0);
        start = 1'b1; stop = 1'b1;
        @(negedge pck0);
        start = 1'b0; stop = 1'b0;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL same_cycle_busy: got %b want 0", busy);
        else n_pass++;
        wait_pe("same_pe1");
        wait_pe("same_pe2");
        @(negedge pck0);
        n_chk++;
        if (busy !== 1'b0 || lf_field !== 1'b0)
            $display("FAIL same_cycle_idle: busy=%b field=%b want 0/0", busy, lf_field);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        pulse_start();
        wait_pe("rst_mid_start");
        @(negedge pck0);
        n_chk++;
        if (lf_field !== 1'b1) $display("FAIL rst_mid_on: field=%b want 1", lf_field);
        else n_pass++;
        repeat (20) @(negedge pck0);
        rst = 1'b1;
        @(negedge pck0);
        n_chk++;
        if (lf_field !== 1'b0 || pck_cnt !== 8'd0 || busy !== 1'b0)
            $display("FAIL rst_mid: field=%b cnt=%0d busy=%b want 0/0/0", lf_field, pck_cnt, busy);
        else n_pass++;
        rst = 1'b0;
    endtask

`ifdef LF_SCHED_STATS_EN
    task automatic test_stats();
        int n;
        load_cfg(8'd95, 16'd1, 16'd1, 4'd0);
        wait_pe("stats_apply");
        pulse_start();
        n_chk++;
        if (burst_cnt !== 16'd0) $display("FAIL stats_clear: got %0d want 0", burst_cnt);
        else n_pass++;
        wait_pe("stats_go");
        for (int i = 0; i < 10; i++) wait_pe("stats_run");
        @(negedge pck0);
        n_chk++;
        if (burst_cnt !== 16'd5) $display("FAIL stats_count: got %0d want 5", burst_cnt);
        else n_pass++;
        pulse_stop();
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge pck0); n++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timebase();
        test_clamp();
        test_burst();
        test_stop();
        test_decim();
        test_start_stop_same();
        test_rst_mid();
`ifdef LF_SCHED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lf_field_sched.md
Name: lf_field_sched

Overview:
Sequencer for the LF read datapath, running at pck0 (24 MHz).
- Generates the pck_cnt / pck_divclk timebase that the LF read front-end uses to drive the antenna, clock the ADC and frame SSP transfers.
- Schedules carrier bursts by driving lf_field through programmed ON/OFF phases (e.g. reader gaps).
- Produces a decimated sample_gate that qualifies which carrier periods are forwarded to the ARM.
- Sits between the ARM-configured registers and the LF read front-end.

Parameters:
DEF_DIV, 95, reset carrier divisor (24 MHz / (2*(95+1)) = 125 kHz)
PH_W, 16, width of ON/OFF phase length counters (carrier periods)
DEC_W, 4, width of decimation setting

Ports:
pck0  in  1  clock, 24 MHz
rst  in  1  synchronous reset, active-high
cfg_load  in  1  strobe; latch cfg_* into shadow registers
cfg_div  in  8  carrier divisor; half-period = cfg_div+1 pck0 cycles
cfg_on  in  PH_W  ON phase length, carrier periods
cfg_off  in  PH_W  OFF phase length, carrier periods; 0 = continuous carrier
cfg_decim  in  DEC_W  forward 1 of every cfg_decim+1 periods
start  in  1  strobe; begin schedule
stop  in  1  strobe; end schedule at next period boundary
pck_cnt  out  8  timebase counter
pck_divclk  out  1  carrier-rate clock
lf_field  out  1  carrier enable to front-end
sample_gate  out  1  high for whole periods selected for forwarding
period_end  out  1  one-cycle pulse on last pck0 cycle of each carrier period
busy  out  1  schedule active (state != IDLE)

Behaviour:
- Reset (rst=1 at posedge): pck_cnt=0, pck_divclk=0, lf_field=0, sample_gate=0, period_end=0, busy=0, state=IDLE, active div=DEF_DIV, on=1, off=0, decim=0, shadow=same, pend=0.
- Timebase free-runs in all states.
  - pck_cnt increments each cycle; when pck_cnt==div_act it wraps to 0 and pck_divclk toggles.
  - One carrier period = 2*(div_act+1) cycles.
- period_end = (pck_cnt==div_act && pck_divclk==1), combinational from registers.
- div_act below 15 is clamped to 15, so SSP counts 8..15 always exist within a half-period.
- cfg_load copies cfg_* into shadow and sets pend. At the next period_end, active<=shadow and pend clears, so the new div applies from the following pck_cnt=0.
  - cfg_load on the same cycle as period_end: the new values land in shadow only and apply at the following period_end.
- cfg_on==0 is treated as 1.
- FSM states: IDLE, ON, OFF, STOPPING. All transitions other than IDLE->ON happen at period_end only.
  - IDLE: lf_field=0. start -> ON at the next period_end; phase count=0, decim count=0, busy=1 from the cycle after start.
  - ON: lf_field=1. At period_end, phase count increments. When count reaches on_act-1: go OFF and reset count if off_act!=0; otherwise stay ON (continuous).
  - OFF: lf_field=0. At period_end, when count reaches off_act-1, go ON and reset count.
  - stop sets stop_req. At the next period_end in ON/OFF -> STOPPING. At the following period_end -> IDLE.
    - In STOPPING, lf_field=0 and sample_gate=0 (one settling period).
    - busy=0 on the first cycle in IDLE.
- start and stop on the same cycle: stop wins and start is ignored. start while busy: ignored. stop in IDLE: ignored.
- lf_field and sample_gate change only on the cycle after period_end, i.e. aligned to pck_cnt=0 with pck_divclk=0, so bursts always contain whole periods.
- sample_gate: in ON/OFF, high for the period when decim count==0.
  - The decim count increments at each period_end and wraps at decim_act.
  - Gating continues through OFF phases, so the ARM sees the gap.
- rst mid-schedule: immediate return to reset values; lf_field drops on the next cycle.

Optional Feature:
LF_SCHED_STATS_EN
- Compiled in: adds output burst_cnt (16 bits). It clears on start and increments on each ON->OFF transition, saturating at 16'hFFFF.
- Compiled out: port absent, no logic.

Test Plan:
- Reset, then free-run 400 cycles -> pck_divclk period = 192 cycles; period_end pulses every 192 cycles; lf_field=0, busy=0.
- cfg_div=10, cfg_load -> div clamped to 15; period = 32 cycles starting after the next period_end.
- cfg_on=3, cfg_off=2, cfg_decim=0, start -> lf_field high for exactly 3*192 cycles, low for 2*192, repeating; sample_gate=1 throughout.
- cfg_decim=3, cfg_off=0, start -> lf_field continuously 1; sample_gate high 192 cycles out of every 768.
- start and stop on the same cycle in IDLE -> busy stays 0. stop mid-ON -> field off after the current period; busy=0 exactly one period later.
- rst asserted mid-ON -> next cycle lf_field=0, pck_cnt=0, busy=0. With LF_SCHED_STATS_EN, after 5 complete bursts burst_cnt=5.
